// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU divider: FSM states, per-precision field
// geometry, canonical special encodings, flag bit positions and small
// packing helpers for signed infinity / zero / NaN.
package fpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    // half precision
    localparam int H_EXP_W  = 5;
    localparam int H_FRAC_W = 10;
    localparam int H_P      = 11;
    localparam int H_N      = H_P + 1;

    // single precision
    localparam int S_EXP_W  = 8;
    localparam int S_FRAC_W = 23;
    localparam int S_P      = 24;
    localparam int S_N      = S_P + 1;

    // datapath sized for the widest precision
    localparam int MANT_W = S_P;
    localparam int REM_W  = S_P + 1;
    localparam int QUO_W  = S_N;
    localparam int EXP_I_W = 10;
    localparam int CNT_W  = 5;

    localparam logic signed [EXP_I_W-1:0] H_BIAS = 10'sd15;
    localparam logic signed [EXP_I_W-1:0] S_BIAS = 10'sd127;
    localparam logic signed [EXP_I_W-1:0] H_EXP_MAX = 10'sd31;
    localparam logic signed [EXP_I_W-1:0] S_EXP_MAX = 10'sd255;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_N - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(S_N - 1);

    localparam logic [15:0] H_QNAN = 16'h7E00;
    localparam logic [31:0] S_QNAN = 32'h7FC0_0000;
    localparam logic [15:0] H_INF  = 16'h7C00;
    localparam logic [31:0] S_INF  = 32'h7F80_0000;

    localparam int FLG_INVALID = 3;
    localparam int FLG_DIVZERO = 2;
    localparam int FLG_OVF     = 1;
    localparam int FLG_UNF     = 0;

    function automatic logic [31:0] pack_inf(input logic ft, input logic s);
        return ft ? {s, S_INF[30:0]} : {16'h0000, s, H_INF[14:0]};
    endfunction

    function automatic logic [31:0] pack_zero(input logic ft, input logic s);
        return ft ? {s, 31'd0} : {16'h0000, s, 15'd0};
    endfunction

    function automatic logic [31:0] pack_qnan(input logic ft);
        return ft ? S_QNAN : {16'h0000, H_QNAN};
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand unpacker shared by the FPU blocks.
// Ports:
//   float_type_i  0 = half (op_i[15:0]), 1 = single (op_i[31:0])
//   op_i          packed operand
//   sign_o        sign bit
//   exp_o         biased exponent, zero-extended to 8 bits
//   mant_o        mantissa with hidden bit, right-aligned (half uses [10:0])
//   is_zero_o     exponent field zero (subnormals flush to zero)
//   is_inf_o      exponent all ones, fraction zero
//   is_nan_o      exponent all ones, fraction nonzero
module fp_unpack
    import fpu_pkg::*;
(
    input  logic              float_type_i,
    input  logic [31:0]       op_i,
    output logic              sign_o,
    output logic [7:0]        exp_o,
    output logic [MANT_W-1:0] mant_o,
    output logic              is_zero_o,
    output logic              is_inf_o,
    output logic              is_nan_o
);

    logic [S_FRAC_W-1:0] frac;
    logic                exp_ones;

    always_comb begin
        if (float_type_i) begin
            sign_o   = op_i[31];
            exp_o    = op_i[30:23];
            frac     = op_i[22:0];
            exp_ones = (op_i[30:23] == 8'hFF);
            mant_o   = {1'b1, op_i[22:0]};
        end else begin
            sign_o   = op_i[15];
            exp_o    = {3'b000, op_i[14:10]};
            frac     = {13'd0, op_i[9:0]};
            exp_ones = (op_i[14:10] == 5'h1F);
            mant_o   = {13'd0, 1'b1, op_i[9:0]};
        end
        is_zero_o = (exp_o == 8'd0);
        is_inf_o  = exp_ones && (frac == '0);
        is_nan_o  = exp_ones && (frac != '0);
    end

endmodule

// File: rtl/fpu_div.sv
// Iterative floating-point divider, Result = A / B, half or single precision.
// Restoring long division, one quotient bit per clock; truncating rounding.
// Ports:
//   clk, reset     clock (rising edge), async active-high reset
//   start          request, sampled only in IDLE
//   floatType      0 = half, 1 = single
//   A, B           dividend, divisor
//   busy           high in DIV and NORM
//   done           one-cycle pulse in DONE
//   fpuFlags       [3] invalid [2] divzero [1] overflow [0] underflow
//   Result         quotient (half: upper 16 bits zero)
//
// state | meaning
// IDLE  | waiting for start; operands unpacked and classified here
// DIV   | one quotient bit per cycle, N iterations
// NORM  | normalise, range-check, pick special or computed result
// DONE  | Result/fpuFlags valid, done pulse
module fpu_div
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        floatType,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [3:0]  fpuFlags,
    output logic [31:0] Result
);

    div_state_t state_q, state_d;

    logic                      ft_q, ft_d;
    logic                      sign_q, sign_d;
    logic signed [EXP_I_W-1:0] exp_q, exp_d;
    logic [REM_W-1:0]          rem_q, rem_d;
    logic [MANT_W-1:0]         mb_q, mb_d;
    logic [QUO_W-1:0]          quo_q, quo_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      spec_q, spec_d;
    logic [31:0]               spec_res_q, spec_res_d;
    logic [3:0]                spec_flg_q, spec_flg_d;
    logic [31:0]               result_q, result_d;
    logic [3:0]                flags_q, flags_d;

    logic              a_sign, b_sign;
    logic [7:0]        a_exp, b_exp;
    logic [MANT_W-1:0] a_mant, b_mant;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    fp_unpack u_unpack_a (
        .float_type_i (floatType),
        .op_i         (A),
        .sign_o       (a_sign),
        .exp_o        (a_exp),
        .mant_o       (a_mant),
        .is_zero_o    (a_zero),
        .is_inf_o     (a_inf),
        .is_nan_o     (a_nan)
    );

    fp_unpack u_unpack_b (
        .float_type_i (floatType),
        .op_i         (B),
        .sign_o       (b_sign),
        .exp_o        (b_exp),
        .mant_o       (b_mant),
        .is_zero_o    (b_zero),
        .is_inf_o     (b_inf),
        .is_nan_o     (b_nan)
    );

    // ---------------- classification at accept ----------------
    logic                      res_sign;
    logic                      spec_hit;
    logic [31:0]               spec_res;
    logic [3:0]                spec_flg;
    logic signed [EXP_I_W-1:0] exp_acc;

    always_comb begin
        res_sign = a_sign ^ b_sign;
        exp_acc  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                 + (floatType ? S_BIAS : H_BIAS);
        spec_hit = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res              = pack_qnan(floatType);
            spec_flg[FLG_INVALID] = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_res              = pack_inf(floatType, res_sign);
            spec_flg[FLG_DIVZERO] = 1'b1;
        end else if (a_inf) begin
            // inf / finite, including inf / 0
            spec_res = pack_inf(floatType, res_sign);
        end else if (a_zero || b_inf) begin
            spec_res = pack_zero(floatType, res_sign);
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ---------------- division step ----------------
    logic             q_bit;
    logic [REM_W-1:0] rem_sub;

    always_comb begin
        q_bit   = 1'b0;
        rem_sub = rem_q;
        if (rem_q >= {1'b0, mb_q}) begin
            q_bit   = 1'b1;
            rem_sub = rem_q - {1'b0, mb_q};
        end
    end

    // ---------------- normalisation ----------------
    logic signed [EXP_I_W-1:0] exp_n;
    logic [S_FRAC_W-1:0]       frac_n;
    logic [31:0]               norm_res;
    logic [3:0]                norm_flg;

    always_comb begin
        exp_n    = exp_q;
        frac_n   = '0;
        norm_res = '0;
        norm_flg = '0;
        // quotient lies in (0.5, 2): a leading zero means one extra shift
        if (ft_q) begin
            if (quo_q[S_N-1]) begin
                frac_n = quo_q[S_N-2:1];
            end else begin
                frac_n = quo_q[S_N-3:0];
                exp_n  = exp_q - 10'sd1;
            end
        end else begin
            if (quo_q[H_N-1]) begin
                frac_n = {13'd0, quo_q[H_N-2:1]};
            end else begin
                frac_n = {13'd0, quo_q[H_N-3:0]};
                exp_n  = exp_q - 10'sd1;
            end
        end
        if (exp_n >= (ft_q ? S_EXP_MAX : H_EXP_MAX)) begin
            norm_res          = pack_inf(ft_q, sign_q);
            norm_flg[FLG_OVF] = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            norm_res          = pack_zero(ft_q, sign_q);
            norm_flg[FLG_UNF] = 1'b1;
        end else if (ft_q) begin
            norm_res = {sign_q, exp_n[S_EXP_W-1:0], frac_n};
        end else begin
            norm_res = {16'h0000, sign_q, exp_n[H_EXP_W-1:0], frac_n[H_FRAC_W-1:0]};
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = spec_hit ? S_NORM : S_DIV;
            S_DIV:  if (cnt_q == (ft_q ? S_LAST : H_LAST)) state_d = S_NORM;
            S_NORM: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state_q == S_DIV) || (state_q == S_NORM);
        done     = (state_q == S_DONE);
        Result   = result_q;
        fpuFlags = flags_q;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        ft_d       = ft_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        mb_d       = mb_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_flg_d = spec_flg_q;
        result_d   = result_q;
        flags_d    = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ft_d       = floatType;
                    sign_d     = res_sign;
                    exp_d      = exp_acc;
                    rem_d      = {1'b0, a_mant};
                    mb_d       = b_mant;
                    quo_d      = '0;
                    cnt_d      = '0;
                    spec_d     = spec_hit;
                    spec_res_d = spec_res;
                    spec_flg_d = spec_flg;
                end
            end
            S_DIV: begin
                // rem_sub < mB, so the shift never loses a set bit
                rem_d = rem_sub << 1;
                quo_d = (quo_q << 1) | {{(QUO_W-1){1'b0}}, q_bit};
                cnt_d = cnt_q + 1'b1;
            end
            S_NORM: begin
                result_d = spec_q ? spec_res_q : norm_res;
                flags_d  = spec_q ? spec_flg_q : norm_flg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ft_q       <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            mb_q       <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            spec_flg_q <= '0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            ft_q       <= ft_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            mb_q       <= mb_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpu_div.sv
module tb_fpu_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic        floatType;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [3:0]  fpuFlags;
    logic [31:0] Result;

    int total = 0;
    int bad   = 0;

    fpu_div dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .floatType (floatType),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .fpuFlags  (fpuFlags),
        .Result    (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ft;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // counts edges from the current sample point until done is seen
    task automatic wait_done(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int   n;
        logic bok;
        @(negedge clk);
        floatType = v.ft;
        A = v.a;
        B = v.b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // operands were captured at the start edge; scramble them now
        A = $urandom;
        B = $urandom;
        floatType = ~v.ft;
        wait_done(n, bok);
        chk($sformatf("v%0d_lat", idx), 32'(n), 32'(v.lat));
        chk($sformatf("v%0d_busy", idx), {31'd0, bok}, 32'd1);
        chk($sformatf("v%0d_res", idx), Result, v.res);
        chk($sformatf("v%0d_flg", idx), {28'd0, fpuFlags}, {28'd0, v.flg});
        chk($sformatf("v%0d_busy_in_done", idx), {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   n;
        int   seen;
        logic bok;

        vecs[0]  = '{1'b0, 32'h0000_3C00, 32'h0000_4000, 32'h0000_3800, 4'b0000, 13};
        vecs[1]  = '{1'b0, 32'h0000_3C00, 32'h0000_4200, 32'h0000_3555, 4'b0000, 13};
        vecs[2]  = '{1'b1, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 26};
        vecs[3]  = '{1'b1, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 26};
        vecs[4]  = '{1'b1, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 1};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1};
        vecs[6]  = '{1'b0, 32'h0000_7BFF, 32'h0000_1400, 32'h0000_7C00, 4'b0010, 13};
        vecs[7]  = '{1'b1, 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 26};
        vecs[8]  = '{1'b1, 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 26};
        vecs[9]  = '{1'b0, 32'h0000_8000, 32'h0000_3C00, 32'h0000_8000, 4'b0000, 1};
        vecs[10] = '{1'b0, 32'h0000_7E01, 32'h0000_3C00, 32'h0000_7E00, 4'b1000, 1};
        vecs[11] = '{1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, 1};
        vecs[12] = '{1'b0, 32'h0000_FC00, 32'h0000_0000, 32'h0000_FC00, 4'b0000, 1};
        vecs[13] = '{1'b1, 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 1};
        // upper half ignored in half mode
        vecs[14] = '{1'b0, 32'hDEAD_3C00, 32'hBEEF_4000, 32'h0000_3800, 4'b0000, 13};
        // half 1.5 / 1.0: leading quotient bit set, nonzero fraction
        vecs[15] = '{1'b0, 32'h0000_3E00, 32'h0000_3C00, 32'h0000_3E00, 4'b0000, 13};

        reset = 1'b1;
        start = 1'b0;
        floatType = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", Result, 32'd0);
        chk("rst_flg", {28'd0, fpuFlags}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run_op(i, vecs[i]);

        // start pulsed during DIV must not restart or queue an operation
        @(negedge clk);
        floatType = 1'b0;
        A = 32'h0000_3C00;
        B = 32'h0000_4000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        A = 32'h0000_3C00;
        B = 32'h0000_4200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, bok);
        chk("div_start_lat", 32'(n), 32'd9);
        chk("div_start_res", Result, 32'h0000_3800);
        // start held while in DONE must be ignored too
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("done_start_ignored", 32'(seen), 32'd0);

        // asynchronous reset mid-DIV
        @(negedge clk);
        floatType = 1'b1;
        A = 32'h3F80_0000;
        B = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_res", Result, 32'd0);
        chk("arst_flg", {28'd0, fpuFlags}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("arst_no_done", 32'(seen), 32'd0);

        run_op(20, vecs[0]);
        run_op(21, vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_div.md
Name: fpu_div

Overview:
- Iterative floating-point divider, Result = A / B, for half (floatType=0) and single (floatType=1) precision.
- Companion to the combinational add/mul FPU. It shares that unit's operand packing and floatType encoding, and adds the inverse of multiplication.
- Division is multi-cycle restoring long division, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the FPU on the execute stage. The stall logic holds the pipeline while busy is high.

Parameters:
- none. All widths and constants are localparams from the shared package.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- floatType  input  1  0 = half (operands in A[15:0]/B[15:0]); 1 = single (A[31:0]/B[31:0])
- A  input  32  dividend
- B  input  32  divisor
- busy  output  1  high while a division is in progress (states DIV, NORM)
- done  output  1  one-cycle pulse, Result/fpuFlags valid
- fpuFlags  output  4  [3] invalid, [2] divide-by-zero, [1] overflow, [0] underflow
- Result  output  32  quotient; in half mode Result[31:16] = 0

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, Result=0, fpuFlags=0, iteration counter=0. Reset mid-operation aborts the operation; no done is produced.
- A, B and floatType are registered when start is accepted. Inputs may change afterwards without effect.
- Field extraction:
  - half: sign [15], exp [14:10], frac [9:0], bias 15, P=11.
  - single: sign [31], exp [30:23], frac [22:0], bias 127, P=24.
  - Sign of the result is sA^sB.
- Operand classes:
  - exp==0 is treated as zero; subnormals are flushed and the fraction is ignored.
  - exp==all-ones with frac==0 is inf; exp==all-ones with frac!=0 is NaN.
- Special cases are resolved at accept. They skip DIV and go IDLE->NORM. Priority is top-down:
  - A or B NaN, 0/0, inf/inf -> canonical NaN (0x7E00 / 0x7FC00000, sign 0), invalid=1.
  - finite nonzero / 0 -> signed inf, divzero=1.
  - inf / finite -> signed inf, no flags.
  - 0 / nonzero, finite / inf -> signed zero, no flags.
- Normal path:
  - Mantissas are mA={1,fracA}, mB={1,fracB}.
  - Exponent is e = expA - expB + bias, held signed, 10 bits wide.
  - Remainder is P+1 bits, initialised to mA.
  - Each DIV cycle: if rem>=mB, the quotient bit is 1 and rem = rem-mB; else the bit is 0. Then rem<<=1, and the bit shifts into q LSB.
  - N = P+1 iterations (half 12, single 25). The counter counts 0..N-1.
- NORM (one cycle):
  - If q[N-1]==1, mantissa = q[N-2 : N-1-(P-1)]. Otherwise mantissa = q[N-3 : N-2-(P-1)] and e = e-1.
  - Rounding is truncation (round toward zero); the remainder is discarded.
  - If e >= all-ones: signed inf, overflow=1.
  - If e <= 0: signed zero, underflow=1.
  - Otherwise the result is packed normally.
- States and transitions:
  - IDLE -> (start) DIV, or NORM for special cases.
  - DIV -> NORM after N iterations.
  - NORM -> DONE (Result/fpuFlags registered).
  - DONE -> IDLE.
- Timing:
  - start sampled at edge E0. Normal: done high in the cycle after edge E(N+1): E13 for half, E26 for single. Special: done high after E1.
  - busy is high from E0 until the NORM->DONE edge.
  - done is high only in DONE; busy=0 in DONE.
  - start is ignored in every state except IDLE, including DONE. Back-to-back operations therefore have a one-cycle gap.
- Result and fpuFlags hold their values until the next NORM->DONE edge. Flags are overwritten per operation, not sticky.

Decomposition:
- Package fpu_pkg holds:
  - state enum {IDLE, DIV, NORM, DONE}.
  - bias, exponent width, fraction width and iteration count per precision.
  - canonical NaN and inf encodings for half and single.
  - flag bit indices.
- Sub-module fp_unpack: combinational; floatType + 32-bit operand -> sign, exp, mantissa with hidden bit, isZero, isInf, isNaN. Instantiated twice. It is reused later to refactor the add/mul FPU.

Test Plan:
- Half 0x3C00 / 0x4000 (1.0/2.0) -> Result 0x00003800, flags 0000, done exactly 13 edges after start edge, busy high throughout.
- Half 0x3C00 / 0x4200 (1/3) -> 0x00003555 (truncated). Single 0x3F800000 / 0x40400000 -> 0x3EAAAAAA, done at E26. Single 0x40C00000 / 0x40000000 -> 0x40400000.
- Single 0x3F800000 / 0x00000000 -> 0x7F800000, flags 0100. Single 0/0 -> 0x7FC00000, flags 1000. Both produce done after E1.
- Half 0x7BFF / 0x1400 -> 0x00007C00, flags 0010. Single 0x00800000 / 0x40000000 -> 0x00000000, flags 0001.
- Sign cases: single 0xC0C00000 / 0x40000000 -> 0xC0400000. Half 0x8000 / 0x3C00 -> 0x00008000, flags 0000.
- Protocol:
  - start pulsed during DIV and during DONE -> ignored, no second done.
  - reset asserted mid-DIV (asynchronously, between edges) -> busy, done, Result and flags are 0 immediately.
  - A new start after reset completes with correct latency.
